// File: rtl/fpu_add_subt_seq_pkg.sv
// Shared definitions for the sequential single-precision add/subtract unit.
package fpu_add_subt_seq_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_ALIGN = 4'd2,
    ST_ADD   = 4'd3,
    ST_NORM  = 4'd4,
    ST_PACK  = 4'd5,
    ST_READY = 4'd6
  } state_e;

  function automatic logic [31:0] signed_inf(input logic sign);
    return {sign, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fpu_add_subt_seq_if.sv
// Operand/result handshake bundle between an initiator and the add/subtract unit.
interface fpu_add_subt_seq_if;
  logic        beg_add_subt;
  logic        ack_add_subt;
  logic        add_subt;
  logic [31:0] Data_X;
  logic [31:0] Data_Y;
  logic        ready_add_subt;
  logic        busy;
  logic [31:0] result;
  logic        overflow_flag;
  logic        underflow_flag;

  modport master (
    output beg_add_subt, ack_add_subt, add_subt, Data_X, Data_Y,
    input  ready_add_subt, busy, result, overflow_flag, underflow_flag
  );

  modport slave (
    input  beg_add_subt, ack_add_subt, add_subt, Data_X, Data_Y,
    output ready_add_subt, busy, result, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/fpu_align_shifter.sv
// Combinational mantissa alignment: right shift, anything of 24 or more clears it.
module fpu_align_shifter (
  input  logic [23:0] mant_i,
  input  logic [7:0]  shamt_i,
  output logic [23:0] mant_o
);

  assign mant_o = (shamt_i >= 8'd24) ? 24'd0 : (mant_i >> shamt_i);

endmodule

// File: rtl/fpu_add_subt_seq.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor, truncating, denormals flushed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for beg_add_subt; operands captured on start
// LOAD     | unpack, order operands so A >= B, decide sign and op
// ALIGN    | shift B's mantissa right by the exponent difference
// ADD      | 25-bit add/subtract, renormalise a carry-out
// NORM     | left-shift one bit per cycle until bit 23 set or exp hits 1
// PACK     | register result and exception flags
// READY    | result valid; leave on ack or when beg is withdrawn
module fpu_add_subt_seq
  import fpu_add_subt_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  fpu_add_subt_seq_if.slave    bus
);

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        op_q, op_d;
  logic [23:0] ma_q, ma_d, mb_q, mb_d;
  logic [8:0]  exp_q, exp_d;
  logic [7:0]  shamt_q, shamt_d;
  logic        sign_q, sign_d, eff_sub_q, eff_sub_d, inf_q, inf_d, unf_q, unf_d;
  logic [24:0] sum_q, sum_d;
  logic [31:0] result_q, result_d;
  logic        ovf_flag_q, ovf_flag_d, unf_flag_q, unf_flag_d;
  logic        ready_q;

  logic [7:0]  ex, ey;
  logic [23:0] mx, my, mb_aligned;
  logic [24:0] add_raw;
  logic        x_ge_y;

  assign ex     = x_q[30:23];
  assign ey     = y_q[30:23];
  assign mx     = (ex == 8'd0) ? 24'd0 : {1'b1, x_q[22:0]};
  assign my     = (ey == 8'd0) ? 24'd0 : {1'b1, y_q[22:0]};
  assign x_ge_y = {ex, mx} >= {ey, my};
  assign add_raw = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                             : ({1'b0, ma_q} + {1'b0, mb_q});

  fpu_align_shifter u_align (
    .mant_i  (mb_q),
    .shamt_i (shamt_q),
    .mant_o  (mb_aligned)
  );

  // Next-state and datapath updates for the operation sequence.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    op_d       = op_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    exp_d      = exp_q;
    shamt_d    = shamt_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    inf_d      = inf_q;
    unf_d      = unf_q;
    sum_d      = sum_q;
    result_d   = result_q;
    ovf_flag_d = ovf_flag_q;
    unf_flag_d = unf_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.beg_add_subt) begin
          x_d     = bus.Data_X;
          y_d     = bus.Data_Y;
          op_d    = bus.add_subt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ma_d      = x_ge_y ? mx : my;
        mb_d      = x_ge_y ? my : mx;
        exp_d     = {1'b0, (x_ge_y ? ex : ey)};
        shamt_d   = x_ge_y ? (ex - ey) : (ey - ex);
        sign_d    = x_ge_y ? x_q[31] : (y_q[31] ^ op_q);
        eff_sub_d = x_q[31] ^ y_q[31] ^ op_q;
        inf_d     = (ex == 8'(EXP_MAX)) || (ey == 8'(EXP_MAX));
        unf_d     = 1'b0;
        state_d   = ST_ALIGN;
      end
      ST_ALIGN: begin
        mb_d    = mb_aligned;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        if (add_raw[24]) begin
          sum_d = add_raw >> 1;
          exp_d = exp_q + 9'd1;
        end else begin
          sum_d = add_raw;
        end
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (sum_q == 25'd0 || sum_q[23]) begin
          state_d = ST_PACK;
        end else if (exp_q > 9'd1) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - 9'd1;
        end else begin
          unf_d   = 1'b1;
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        ovf_flag_d = 1'b0;
        unf_flag_d = 1'b0;
        if (inf_q || exp_q >= 9'(EXP_MAX)) begin
          result_d   = signed_inf(sign_q);
          ovf_flag_d = 1'b1;
        end else if (sum_q == 25'd0) begin
          result_d = 32'h0;
        end else if (unf_q) begin
          result_d   = 32'h0;
          unf_flag_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_q[7:0], sum_q[22:0]};
        end
        state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.ack_add_subt || !bus.beg_add_subt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= 1'b0;
      ma_q       <= '0;
      mb_q       <= '0;
      exp_q      <= '0;
      shamt_q    <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      inf_q      <= 1'b0;
      unf_q      <= 1'b0;
      sum_q      <= '0;
      result_q   <= '0;
      ovf_flag_q <= 1'b0;
      unf_flag_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      exp_q      <= exp_d;
      shamt_q    <= shamt_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      inf_q      <= inf_d;
      unf_q      <= unf_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      ovf_flag_q <= ovf_flag_d;
      unf_flag_q <= unf_flag_d;
      ready_q    <= (state_d == ST_READY);
    end
  end

  assign bus.ready_add_subt = ready_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.result         = result_q;
  assign bus.overflow_flag  = ovf_flag_q;
  assign bus.underflow_flag = unf_flag_q;

endmodule

// File: tb/tb_fpu_add_subt_seq.sv
// Randomised and directed bench for fpu_add_subt_seq against an arithmetic reference.
module tb_fpu_add_subt_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fpu_add_subt_seq_if bus();

  fpu_add_subt_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unpacked operands.
  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic op,
                       output logic [31:0] r, output logic ov, output logic un,
                       output int n);
    int ex, ey, mx, my, ea, eb, ma, mb, s, e, d;
    bit sa, esub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex == 0) ? 0 : int'({1'b1, x[22:0]});
    my = (ey == 0) ? 0 : int'({1'b1, y[22:0]});
    esub = x[31] ^ y[31] ^ op;
    if (ex > ey || (ex == ey && mx >= my)) begin
      ea = ex; ma = mx; eb = ey; mb = my; sa = x[31];
    end else begin
      ea = ey; ma = my; eb = ex; mb = mx; sa = y[31] ^ op;
    end
    d  = ea - eb;
    mb = (d >= 24) ? 0 : (mb >> d);
    s  = esub ? (ma - mb) : (ma + mb);
    e  = ea;
    n  = 0;
    ov = 1'b0;
    un = 1'b0;
    if (s >= (1 << 24)) begin
      s = s >> 1;
      e = e + 1;
    end
    if (s != 0) begin
      while (s < (1 << 23) && e > 1) begin
        s = s << 1;
        e = e - 1;
        n++;
      end
    end
    if (ex == 255 || ey == 255 || e >= 255) begin
      r  = {sa, 8'hFF, 23'h0};
      ov = 1'b1;
    end else if (s == 0) begin
      r = 32'h0;
    end else if (s < (1 << 23)) begin
      r  = 32'h0;
      un = 1'b1;
    end else begin
      r = {sa, e[7:0], s[22:0]};
    end
  endtask

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic op);
    @(negedge clk);
    bus.Data_X       = x;
    bus.Data_Y       = y;
    bus.add_subt     = op;
    bus.beg_add_subt = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_add_subt) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic op);
    logic [31:0] er;
    logic eo, eu;
    int en, lat;
    model(x, y, op, er, eo, eu, en);
    start_op(x, y, op);
    wait_ready(lat);
    chk({tag, ".lat"}, lat, 5 + en);
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".ovf"}, {31'b0, bus.overflow_flag}, {31'b0, eo});
    chk({tag, ".unf"}, {31'b0, bus.underflow_flag}, {31'b0, eu});
    bus.ack_add_subt = 1'b1;
    bus.beg_add_subt = 1'b0;
    @(negedge clk);
    bus.ack_add_subt = 1'b0;
  endtask

  logic [31:0] rx, ry, hr;
  logic        hov, hun;
  int          hn, lat, rdy_cnt;

  initial begin
    bus.beg_add_subt = 1'b0;
    bus.ack_add_subt = 1'b0;
    bus.add_subt     = 1'b0;
    bus.Data_X       = '0;
    bus.Data_Y       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'b0, bus.ready_add_subt}, 32'd0);
    chk("rst.busy", {31'b0, bus.busy}, 32'd0);
    chk("rst.result", bus.result, 32'h0);
    chk("rst.flags", {30'b0, bus.overflow_flag, bus.underflow_flag}, 32'd0);
    reset = 1'b0;

    do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0);
    chk("one_plus_one.val", bus.result, 32'h40000000);
    do_op("1p5_minus_1", 32'h3FC00000, 32'h3F800000, 1'b1);
    chk("1p5_minus_1.val", bus.result, 32'h3F000000);
    do_op("three_minus_three", 32'h40400000, 32'h40400000, 1'b1);
    chk("three_minus_three.val", bus.result, 32'h00000000);
    do_op("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    chk("max_plus_max.val", bus.result, 32'h7F800000);
    chk("max_plus_max.ovfc", {31'b0, bus.overflow_flag}, 32'd1);

    // Hold in READY with beg high and no ack.
    start_op(32'h40000000, 32'h3F800000, 1'b0);
    wait_ready(lat);
    chk("hold.lat", lat, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold.ready", {31'b0, bus.ready_add_subt}, 32'd1);
      chk("hold.result", bus.result, 32'h40400000);
    end
    bus.ack_add_subt = 1'b1;
    @(negedge clk);
    chk("ack.ready", {31'b0, bus.ready_add_subt}, 32'd0);
    chk("ack.busy", {31'b0, bus.busy}, 32'd0);
    bus.ack_add_subt = 1'b0;
    bus.beg_add_subt = 1'b0;

    // Withdraw beg on the ready cycle: exactly one ready cycle.
    start_op(32'h3F800000, 32'h40000000, 1'b1);
    wait_ready(lat);
    rdy_cnt = bus.ready_add_subt ? 1 : 0;
    bus.beg_add_subt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ready_add_subt) rdy_cnt++;
    end
    chk("drop.ready_cycles", rdy_cnt, 32'd1);
    chk("drop.result", bus.result, 32'hBF800000);

    // Reset during a long normalisation.
    do_op("pre_abort", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    start_op(32'h3F800001, 32'h3F800000, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort.in_norm_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    bus.beg_add_subt = 1'b0;
    @(negedge clk);
    chk("abort.ready", {31'b0, bus.ready_add_subt}, 32'd0);
    chk("abort.busy", {31'b0, bus.busy}, 32'd0);
    chk("abort.result", bus.result, 32'h0);
    chk("abort.flags", {30'b0, bus.overflow_flag, bus.underflow_flag}, 32'd0);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready_add_subt) rdy_cnt++;
    end
    chk("abort.no_ready", rdy_cnt, 32'd0);
    do_op("after_abort", 32'h3F800001, 32'h3F800000, 1'b1);
    model(32'h3F800001, 32'h3F800000, 1'b1, hr, hov, hun, hn);
    chk("after_abort.n", hn, 32'd23);

    // Randomised operands, biased toward close exponents and specials.
    for (int t = 0; t < 300; t++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = $urandom;
        1: begin
          ry = $urandom;
          ry[30:23] = rx[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
        end
        2: begin
          ry = rx;
          ry[7:0] = 8'($urandom);
          ry[31]  = 1'($urandom);
        end
        default: begin
          ry = $urandom;
          case ($urandom_range(0, 2))
            0: ry[30:23] = 8'd0;
            1: ry[30:23] = 8'd255;
            default: begin
              ry[30:23] = 8'd254;
              rx[30:23] = 8'd254;
            end
          endcase
        end
      endcase
      if ($urandom_range(0, 1) == 1) do_op("rand", rx, ry, 1'($urandom));
      else do_op("rand", ry, rx, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
